// File: rtl/i2c_target.sv
// i2c_target: I2C target that bridges bus transfers to a small register bank.
// Protocol: START, device address + R/W, register address, then write data
// bytes or read data bytes, ended by STOP, repeated START or master NACK.
// Optional feature (macro I2C_AUTO_INC_EN): reg_addr advances modulo
// 2^ADDR_W after every register write and after every master-ACKed read byte.
// Without the macro, reg_addr holds for the whole transaction.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h70,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam int unsigned      CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_DEVADDR = 4'd1;
  localparam logic [3:0] ST_DEVACK  = 4'd2;
  localparam logic [3:0] ST_REGADDR = 4'd3;
  localparam logic [3:0] ST_REGACK  = 4'd4;
  localparam logic [3:0] ST_WRDATA  = 4'd5;
  localparam logic [3:0] ST_WRACK   = 4'd6;
  localparam logic [3:0] ST_RDDATA  = 4'd7;
  localparam logic [3:0] ST_RDACK   = 4'd8;

  // Synchronizer and edge-detect history
  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Bus events derived from synchronized samples only
  logic scl_rise, scl_fall, start_det, stop_det;

  // FSM and datapath registers with their next values
  logic [3:0]        state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic [DATA_W-1:0] byte_in;
  logic              last_bit;
  logic              rw, rw_n;
  logic              rd_load, rd_load_n;
  logic              sda_oe_n;
  logic [ADDR_W-1:0] reg_addr_n;
  logic [DATA_W-1:0] reg_wdata_n;
  logic              reg_we_n;
  logic              reg_re_n;
  logic              busy_n;

  // Two-stage synchronizers plus previous-sample register; idle bus level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  // SCL edges; START/STOP require SCL stable high across the SDA edge
  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  // Byte as it will look once the current SDA sample is shifted in (MSB first)
  assign byte_in  = {sr[DATA_W-2:0], sda_sync};
  assign last_bit = (bit_cnt == LAST_BIT);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      rw        <= 1'b0;
      rd_load   <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      sr        <= sr_n;
      rw        <= rw_n;
      rd_load   <= rd_load_n;
      sda_oe    <= sda_oe_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_we    <= reg_we_n;
      reg_re    <= reg_re_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    sr_n        = sr;
    rw_n        = rw;
    rd_load_n   = reg_re;
    sda_oe_n    = sda_oe;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    reg_we_n    = 1'b0;
    reg_re_n    = 1'b0;
    busy_n      = busy;

`ifdef I2C_AUTO_INC_EN
    // Advance the register pointer the cycle after each write strobe
    if (reg_we) begin
      reg_addr_n = reg_addr + ADDR_W'(1);
    end
`endif

    // Bank data is valid the cycle after reg_re; load it for transmission
    if (rd_load) begin
      sr_n = reg_rdata;
    end

    if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ST_DEVADDR;
      bit_cnt_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
        end

        ST_DEVADDR: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
          if (scl_rise) begin
            sr_n      = byte_in;
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (last_bit) begin
              bit_cnt_n = '0;
              if (byte_in[DATA_W-1:1] == DEV_ADDR) begin
                state_n = ST_DEVACK;
                rw_n    = byte_in[0];
                busy_n  = 1'b1;
              end else begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
              end
            end
          end
        end

        ST_DEVACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b1;
          end
          if (scl_rise) begin
            bit_cnt_n = '0;
            if (rw) begin
              state_n  = ST_RDDATA;
              reg_re_n = 1'b1;
            end else begin
              state_n = ST_REGADDR;
            end
          end
        end

        ST_REGADDR: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
          if (scl_rise) begin
            sr_n      = byte_in;
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (last_bit) begin
              bit_cnt_n  = '0;
              reg_addr_n = byte_in[ADDR_W-1:0];
              state_n    = ST_REGACK;
            end
          end
        end

        ST_REGACK, ST_WRACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b1;
          end
          if (scl_rise) begin
            bit_cnt_n = '0;
            state_n   = ST_WRDATA;
          end
        end

        ST_WRDATA: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
          if (scl_rise) begin
            sr_n      = byte_in;
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (last_bit) begin
              bit_cnt_n   = '0;
              reg_wdata_n = byte_in;
              reg_we_n    = 1'b1;
              state_n     = ST_WRACK;
            end
          end
        end

        ST_RDDATA: begin
          // Drive a 0 bit by pulling low, release for a 1 bit
          if (scl_fall) begin
            sda_oe_n = ~sr[DATA_W-1];
          end
          if (scl_rise) begin
            sr_n      = {sr[DATA_W-2:0], 1'b0};
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (last_bit) begin
              bit_cnt_n = '0;
              state_n   = ST_RDACK;
            end
          end
        end

        ST_RDACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end
          if (scl_rise) begin
            bit_cnt_n = '0;
            if (!sda_sync) begin
              state_n  = ST_RDDATA;
              reg_re_n = 1'b1;
`ifdef I2C_AUTO_INC_EN
              reg_addr_n = reg_addr + ADDR_W'(1);
`endif
            end else begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
            end
          end
        end

        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level master driving i2c_target, with a register-bank
// model and a scoreboard of expected write/read strobes.
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h70;
  localparam int         TQ  = 50;
`ifdef I2C_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  int checks;
  int failures;
  bit oe_seen;

  // Reference model: register contents and register pointer
  logic [7:0] mem_m [8];
  logic [2:0] m_ptr;
  // Bench-side register bank attached to the DUT
  logic [7:0] bank [8];

  logic [10:0] exp_wr[$];
  logic [2:0]  exp_rd[$];
  logic [7:0]  tx_q[$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_target #(.DEV_ADDR(DEV), .ADDR_W(3), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Register bank: read data valid the cycle after reg_re
  always @(posedge clk) begin
    if (reg_we) bank[reg_addr] = reg_wdata;
    if (reg_re) reg_rdata <= bank[reg_addr];
  end

  // Monitor: pops expected strobes as the DUT presents them
  always @(negedge clk) begin
    logic [10:0] ew;
    logic [2:0]  er;
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (reg_we || reg_re) chk("we_re_exclusive", {31'b0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        if (exp_wr.size() == 0) chk("we_unexpected", 32'(exp_wr.size()), 32'd1);
        else begin
          ew = exp_wr.pop_front();
          chk("we_addr", {29'b0, reg_addr}, {29'b0, ew[10:8]});
          chk("we_data", {24'b0, reg_wdata}, {24'b0, ew[7:0]});
        end
      end
      if (reg_re) begin
        if (exp_rd.size() == 0) chk("re_unexpected", 32'(exp_rd.size()), 32'd1);
        else begin
          er = exp_rd.pop_front();
          chk("re_addr", {29'b0, reg_addr}, {29'b0, er});
        end
      end
    end
  end

  task automatic bus_start();
    sda_m = 1'b0; #(2*TQ);
    scl_m = 1'b0; #TQ;
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; #TQ;
    scl_m = 1'b1; #(2*TQ);
    sda_m = 1'b0; #(2*TQ);
    scl_m = 1'b0; #TQ;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #TQ;
    scl_m = 1'b1; #(2*TQ);
    sda_m = 1'b1; #(2*TQ);
  endtask

  task automatic wbit(input logic b);
    sda_m = b; #TQ;
    scl_m = 1'b1; #(2*TQ);
    scl_m = 1'b0; #TQ;
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; #TQ;
    scl_m = 1'b1; #TQ;
    b = sda_line; #TQ;
    scl_m = 1'b0; #TQ;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    acked = ~a;
  endtask

  task automatic rbyte(input logic master_ack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(~master_ack);
  endtask

  // Address byte (write), then tx_q: register address, then data bytes
  task automatic write_phase(input logic [6:0] dev);
    logic acked;
    bit   match;
    match = (dev == DEV);
    wbyte({dev, 1'b0}, acked);
    chk("dev_ack", {31'b0, acked}, {31'b0, match});
    if (match) chk("busy_after_ack", {31'b0, busy}, 32'd1);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (match) begin
        if (i == 0) m_ptr = tx_q[0][2:0];
        else begin
          exp_wr.push_back({m_ptr, tx_q[i]});
          mem_m[m_ptr] = tx_q[i];
          if (AUTO_INC) m_ptr = 3'((m_ptr + 1) % 8);
        end
      end
      wbyte(tx_q[i], acked);
      chk($sformatf("byte%0d_ack", i), {31'b0, acked}, {31'b0, match});
    end
  endtask

  // Address byte (read), then n bytes; last byte NACKed by the master
  task automatic read_phase(input int n);
    logic       acked;
    logic [7:0] d;
    logic [7:0] e;
    logic [2:0] nxt;
    exp_rd.push_back(m_ptr);
    wbyte({DEV, 1'b1}, acked);
    chk("rd_dev_ack", {31'b0, acked}, 32'd1);
    for (int k = 0; k < n; k++) begin
      e   = mem_m[m_ptr];
      nxt = AUTO_INC ? 3'((m_ptr + 1) % 8) : m_ptr;
      if (k != n - 1) exp_rd.push_back(nxt);
      rbyte(k != n - 1, d);
      chk("rd_data", {24'b0, d}, {24'b0, e});
      if (k != n - 1) m_ptr = nxt;
    end
    chk("busy_after_nack", {31'b0, busy}, 32'd0);
  endtask

  task automatic finish_txn();
    bus_stop();
    chk("busy_after_stop", {31'b0, busy}, 32'd0);
    chk("oe_after_stop", {31'b0, sda_oe}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [6:0] dev;
    int         mode;
    int         nb;

    checks = 0; failures = 0; oe_seen = 1'b0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; m_ptr = 3'd0; reg_rdata = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      bank[i]  = b;
      mem_m[i] = b;
    end
    #22;
    chk("rst_sda_oe",    {31'b0, sda_oe},    32'd0);
    chk("rst_reg_addr",  {29'b0, reg_addr},  32'd0);
    chk("rst_reg_wdata", {24'b0, reg_wdata}, 32'd0);
    chk("rst_reg_we",    {31'b0, reg_we},    32'd0);
    chk("rst_reg_re",    {31'b0, reg_re},    32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    #20 rst = 1'b0;
    #60;

    // Single register write
    tx_q = '{8'h02, 8'hA5};
    bus_start(); write_phase(DEV); finish_txn();

    // Store 3C at register 2, then point at it and read it back after Sr
    tx_q = '{8'h02, 8'h3C};
    bus_start(); write_phase(DEV); finish_txn();
    tx_q = '{8'h02};
    bus_start(); write_phase(DEV); bus_rstart(); read_phase(1); finish_txn();

    // Foreign address: never acknowledged, SDA never pulled
    oe_seen = 1'b0;
    tx_q = '{8'h05, 8'hA5};
    bus_start(); write_phase(7'h71); finish_txn();
    chk("nomatch_no_oe", {31'b0, oe_seen}, 32'd0);

    // Two data bytes starting at the top register
    tx_q = '{8'h07, 8'h11, 8'h22};
    bus_start(); write_phase(DEV); finish_txn();

    // STOP in the middle of a data byte
    tx_q = '{8'h03};
    bus_start(); write_phase(DEV);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    finish_txn();

    // Reset while the address ACK is being driven
    b = {DEV, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    sda_m = 1'b1; #TQ;
    scl_m = 1'b1; #TQ;
    chk("ack_driven", {31'b0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_sda_oe",    {31'b0, sda_oe},    32'd0);
    chk("arst_reg_addr",  {29'b0, reg_addr},  32'd0);
    chk("arst_reg_wdata", {24'b0, reg_wdata}, 32'd0);
    chk("arst_reg_we",    {31'b0, reg_we},    32'd0);
    chk("arst_reg_re",    {31'b0, reg_re},    32'd0);
    chk("arst_busy",      {31'b0, busy},      32'd0);
    m_ptr = 3'd0;
    #49 rst = 1'b0;
    #100;
    tx_q = '{8'h04, 8'h5A};
    bus_start(); write_phase(DEV); finish_txn();

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      mode = int'($urandom_range(0, 2));
      dev  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      bus_start();
      if (mode == 2) begin
        read_phase(int'($urandom_range(1, 3)));
      end else begin
        tx_q.delete();
        tx_q.push_back(8'($urandom));
        nb = int'($urandom_range(0, 3));
        for (int j = 0; j < nb; j++) tx_q.push_back(8'($urandom));
        write_phase(dev);
        if (mode == 1 && dev == DEV) begin
          bus_rstart();
          read_phase(int'($urandom_range(1, 3)));
        end
      end
      finish_txn();
    end

    #200;
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h70: 7-bit I2C device address this target answers to.
REQ-002 Parameter ADDR_W, default 3: register-bank address width.
REQ-003 Parameter DATA_W, fixed 8: register data width.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 scl_i  input  1  raw I2C SCL from pad; asynchronous.
REQ-007 sda_i  input  1  raw I2C SDA from pad; asynchronous.
REQ-008 sda_oe  output  1  open-drain pull-down enable: 1 = drive SDA low, 0 = release.
REQ-009 reg_addr  output  ADDR_W  register address presented to the bank.
REQ-010 reg_wdata  output  8  write data to the bank.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read strobe.
REQ-013 reg_rdata  input  8  read data from the bank, valid the cycle after reg_re.
REQ-014 busy  output  1  high from address-matched ACK until STOP or return to IDLE.

Function
REQ-015 scl_i and sda_i pass through a 2-FF synchronizer; a further register holds the previous sample for edge detection; all protocol logic uses the synchronized values only.
REQ-016 clk is at least 16x the SCL frequency.
REQ-017 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are flagged 3 clk after the pad edge.
REQ-018 States: IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WRDATA, WRACK, RDDATA, RDACK.
REQ-019 START in any state (repeated START included) -> DEVADDR with bit counter cleared; STOP in any state -> IDLE with sda_oe = 0.
REQ-020 Bits are shifted in MSB first on SCL rising; sda_oe changes only on SCL falling, except release on STOP or reset.
REQ-021 DEVADDR: after 8 bits, if bits[7:1] == DEV_ADDR -> DEVACK, else -> IDLE and SDA stays released until the next START.
REQ-022 DEVACK: drive ACK (sda_oe = 1) for one SCL period; R/W = 0 -> REGADDR, R/W = 1 -> RDDATA.
REQ-023 REGADDR: 8th bit loads the low ADDR_W bits into reg_addr (upper bits ignored) -> REGACK (ACK) -> WRDATA.
REQ-024 WRDATA: one clk after the 8th-bit SCL rise, reg_wdata = byte and reg_we = 1 for one clk at the current reg_addr -> WRACK (ACK) -> WRDATA.
REQ-025 RDDATA entry: reg_re = 1 for one clk at the current reg_addr; the next clk captures reg_rdata into the shift register; MSB is driven on the first SCL fall; a bit value of 0 drives sda_oe = 1, 1 releases.
REQ-026 RDACK: master ACK (SDA = 0) -> RDDATA with a new reg_re; master NACK -> IDLE.
REQ-027 reg_we and reg_re are never high in the same cycle; neither is asserted outside WRDATA/RDDATA.
REQ-028 Partial byte (START/STOP before the 8th bit) produces no strobe and no reg_addr change.

Reset
REQ-029 On rst: state = IDLE, sda_oe = 0, reg_addr = 0, reg_wdata = 0, reg_we = 0, reg_re = 0, busy = 0, synchronizers = 1.
REQ-030 Reset mid-transfer aborts immediately; the next transaction requires a fresh START.

Configuration
REQ-031 Macro I2C_AUTO_INC_EN defined: reg_addr increments modulo 2^ADDR_W after each reg_we and after each master ACK in RDACK (7 -> 0 when ADDR_W = 3).
REQ-032 I2C_AUTO_INC_EN undefined: reg_addr holds; successive bytes in one transaction access the same register.

Verification
REQ-033 Write E0 02 A5 + STOP -> three ACKs, one reg_we with reg_addr = 2 and reg_wdata = A5, busy low after STOP.
REQ-034 Write E0 02, Sr E1, read one byte + NACK with reg_rdata = 3C -> reg_re at addr 2, SDA bits 0011_1100, state IDLE.
REQ-035 Write E2 05 ... (address 0x71) -> no ACK, sda_oe never 1, no strobes.
REQ-036 With I2C_AUTO_INC_EN, write E0 07 11 22 -> reg_we at addr 7 (data 11), then addr 0 (data 22); without the macro, both writes go to addr 7.
REQ-037 STOP after 4 bits of a data byte -> no reg_we, IDLE, sda_oe = 0.
REQ-038 rst pulsed while ACK is driven -> sda_oe = 0 and all outputs at reset values asynchronously; the next full write transaction succeeds.
